// File: rtl/muldiv_scheduler.sv
// rtl/muldiv_scheduler.sv - multi-cycle MULT/MULTU/DIV/DIVU scheduler producing HI/LO results
//
// Ports:
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   start      : EX-stage request for a HI/LO arithmetic op
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      : rs data (multiplicand / dividend)
//   src_b      : rt data (multiplier / divisor)
//   flush      : pipeline flush, cancels any operation
//   stall      : freeze EX and earlier stages
//   busy       : state is not IDLE
//   hilo_wen   : one-cycle write strobe for HI and LO
//   hi_result  : value for HI (product[63:32] or remainder)
//   lo_result  : value for LO (product[31:0] or quotient)
//   div_zero   : completed divide had divisor 0, valid with hilo_wen
module muldiv_scheduler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hilo_wen,
    output logic [31:0] hi_result,
    output logic [31:0] lo_result,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        accept;
    logic [63:0] prod;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic        q_bit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic        neg_quo;
    logic        neg_rem;

    assign accept = (state_q == ST_IDLE) && start && !flush;

    // Sign-extending both operands to 64 bits makes the low 64 bits of a
    // plain multiply correct for both signed and unsigned forms.
    assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    // Dividend magnitude is loaded into the quotient shift register at accept.
    assign a_mag_in = (~op[0] & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag    = (sgn_q & b_q[31]) ? (32'd0 - b_q) : b_q;

    // Restoring step: partial remainder can reach 33 bits after the shift, in
    // which case it is certainly >= the 32-bit divisor.
    assign rem_shift = {rem_q, quo_q[31]};
    assign q_bit     = rem_shift[32] | (rem_shift[31:0] >= b_mag);
    assign rem_next  = q_bit ? (rem_shift[31:0] - b_mag) : rem_shift[31:0];
    assign quo_next  = {quo_q[30:0], q_bit};

    assign neg_quo = sgn_q & (a_q[31] ^ b_q[31]);
    assign neg_rem = sgn_q & a_q[31];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sgn_d = ~op[0];
                    a_d   = src_a;
                    b_d   = src_b;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = a_mag_in;
                    dz_d  = 1'b0;
                    if (!op[1]) begin
                        state_d = ST_MUL;
                    end else if (src_b == 32'd0) begin
                        state_d = ST_DONE;
                        hi_d    = src_a;
                        lo_d    = 32'hFFFF_FFFF;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                state_d      = ST_DONE;
                {hi_d, lo_d} = prod;
            end
            ST_DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    lo_d    = neg_quo ? (32'd0 - quo_next) : quo_next;
                    hi_d    = neg_rem ? (32'd0 - rem_next) : rem_next;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A flush abandons the operation and keeps the previously published result.
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = dz_q;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    // Gated by resetn so a start seen while held in reset never freezes the pipe.
    assign stall     = resetn & (accept | (state_q == ST_MUL) | (state_q == ST_DIV));
    assign hilo_wen  = (state_q == ST_DONE) && !flush;
    assign div_zero  = hilo_wen & dz_q;
    assign hi_result = hi_q;
    assign lo_result = lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// tb/tb_muldiv_scheduler.sv - directed self-checking bench for muldiv_scheduler
module tb_muldiv_scheduler;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hilo_wen;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        div_zero;

    int n_total = 0;
    int n_bad   = 0;

    muldiv_scheduler dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .hilo_wen  (hilo_wen),
        .hi_result (hi_result),
        .lo_result (lo_result),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge (cycle T). Issues one op and
    // follows it to its hilo_wen strobe. With noise set, start is held high
    // with a MULTU request while the op is in flight; it must be ignored.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat, input bit noise);
        bit          found;
        int          lat;
        int          nst;
        logic [31:0] ghi;
        logic [31:0] glo;
        logic        gdz;
        logic        gst;
        found = 0; lat = 0; nst = 1;
        ghi = '0; glo = '0; gdz = 1'b0; gst = 1'b0;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        check({tag, "_stall_T"}, stall, 1'b1);
        @(posedge clk); #1;
        start = noise;
        if (noise) begin
            op = 2'b01; src_a = 32'd3; src_b = 32'd3;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hilo_wen) begin
                found = 1; lat = k;
                ghi = hi_result; glo = lo_result; gdz = div_zero; gst = stall;
                start = 1'b0;
            end else if (stall) begin
                nst++;
            end
            @(posedge clk); #1;
            if (found) break;
        end
        check({tag, "_wen_seen"}, found, 1'b1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_hi"}, ghi, ehi);
        check({tag, "_lo"}, glo, elo);
        check({tag, "_div_zero"}, gdz, edz);
        check({tag, "_stall_cycles"}, nst, elat);
        check({tag, "_stall_done"}, gst, 1'b0);
        check({tag, "_wen_after"}, hilo_wen, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_lo_hold"}, lo_result, elo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_wen;
        bit seen_busy;
        resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wen", hilo_wen, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst_hi", hi_result, 32'd0);
        check("rst_lo", lo_result, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // tag, op, a, b, hi, lo, dz, latency, noise
        run_op("mult_m3x5",  2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2,  1'b0);
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2,  1'b0);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2,  1'b0);
        run_op("multu_big",  2'b01, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 1'b0, 2,  1'b0);
        run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 33, 1'b1);
        run_op("divu_by0",   2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1, 1,  1'b0);
        run_op("div_by0",    2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1,  1'b0);
        run_op("div_7_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 1'b0);
        run_op("divu_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        run_op("divu_5_max", 2'b11, 32'd5,         32'hFFFF_FFFF, 32'd5,         32'd0,         1'b0, 33, 1'b0);

        // Flush at T+10 of a DIV, then a fresh start at T+11.
        seen_wen = 0;
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (hilo_wen) seen_wen = 1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_T10", busy, 1'b1);
        check("flush_wen_T10", hilo_wen, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_early_wen", seen_wen, 1'b0);
        check("flush_busy_T11", busy, 1'b0);
        run_op("post_flush", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);

        // Flush in DONE suppresses the write strobe.
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_done_wen", hilo_wen, 1'b0);
        check("flush_done_dz", div_zero, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_busy", busy, 1'b0);

        // Asynchronous reset at T+5 of a DIV.
        start = 1'b1; op = 2'b10; src_a = 32'd77; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_stall", stall, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_wen", hilo_wen, 1'b0);
        check("arst_hi", hi_result, 32'd0);
        check("arst_lo", lo_result, 32'd0);
        start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2;
        #1;
        check("arst_stall_start", stall, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        seen_wen = 0; seen_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_wen) seen_wen = 1;
            if (busy) seen_busy = 1;
        end
        check("arst_no_wen", seen_wen, 1'b0);
        check("arst_no_busy", seen_busy, 1'b0);
        @(posedge clk); #1;
        run_op("post_reset", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
